// File: rtl/host_frame_rx.sv
// Validating deframer: hunts SYNC, reads LEN, buffers the payload, checks an 8-bit checksum
// and replays only verified payloads as AXI-Stream. Bad or stalled frames are counted and dropped.
module host_frame_rx #(
    parameter int unsigned MAX_LEN        = 64,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             frame_ok,
    output logic [CNT_W-1:0] err_len,
    output logic [CNT_W-1:0] err_csum,
    output logic [CNT_W-1:0] err_timeout
);

    localparam int unsigned AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MaxLen8     = 8'(MAX_LEN);
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StHunt, StLen, StPay, StCsum, StDrain} state_e;

    state_e           state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       widx_q, widx_d;
    logic [7:0]       ridx_q, ridx_d;
    logic [31:0]      idle_q, idle_d;
    logic             ready_q, ready_d;
    logic             frame_ok_q, frame_ok_d;
    logic [CNT_W-1:0] err_len_q, err_csum_q, err_timeout_q;
    logic             inc_len, inc_csum, inc_timeout;
    logic             wr_en;
    logic             accept;
    logic             m_last;
    logic [7:0]       csum_chk;
    logic [7:0]       mem_q [2**AW];

    assign accept   = s_axis_tvalid & ready_q;
    assign csum_chk = sum_q + s_axis_tdata;
    assign m_last   = (ridx_q == len_q - 8'd1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        widx_d      = widx_q;
        ridx_d      = ridx_q;
        idle_d      = idle_q;
        frame_ok_d  = 1'b0;
        inc_len     = 1'b0;
        inc_csum    = 1'b0;
        inc_timeout = 1'b0;
        wr_en       = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (accept && s_axis_tdata == SYNC_BYTE) begin
                    state_d = StLen;
                    idle_d  = '0;
                end
            end
            StLen: begin
                if (accept) begin
                    idle_d = '0;
                    if (s_axis_tdata == 8'd0 || s_axis_tdata > MaxLen8) begin
                        inc_len = 1'b1;
                        state_d = StHunt;
                    end else begin
                        len_d   = s_axis_tdata;
                        sum_d   = s_axis_tdata;
                        widx_d  = '0;
                        state_d = StPay;
                    end
                end
            end
            StPay: begin
                if (accept) begin
                    idle_d = '0;
                    wr_en  = 1'b1;
                    sum_d  = sum_q + s_axis_tdata;
                    widx_d = widx_q + 8'd1;
                    if (widx_q == len_q - 8'd1) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    idle_d = '0;
                    if (csum_chk == 8'd0) begin
                        frame_ok_d = 1'b1;
                        ridx_d     = '0;
                        state_d    = StDrain;
                    end else begin
                        inc_csum = 1'b1;
                        state_d  = StHunt;
                    end
                end
            end
            StDrain: begin
                if (m_axis_tready) begin
                    ridx_d = ridx_q + 8'd1;
                    if (m_last) begin
                        state_d = StHunt;
                    end
                end
            end
            default: state_d = StHunt;
        endcase

        // Idle cycles mid-frame; a stalled sender must not wedge the deframer.
        if ((state_q == StLen || state_q == StPay || state_q == StCsum) && !accept &&
            TIMEOUT_CYCLES != 0) begin
            if (idle_q == TimeoutLast) begin
                inc_timeout = 1'b1;
                idle_d      = '0;
                state_d     = StHunt;
            end else begin
                idle_d = idle_q + 32'd1;
            end
        end

        ready_d = (state_d != StDrain);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHunt;
            len_q         <= '0;
            sum_q         <= '0;
            widx_q        <= '0;
            ridx_q        <= '0;
            idle_q        <= '0;
            ready_q       <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_len_q     <= '0;
            err_csum_q    <= '0;
            err_timeout_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            widx_q     <= widx_d;
            ridx_q     <= ridx_d;
            idle_q     <= idle_d;
            ready_q    <= ready_d;
            frame_ok_q <= frame_ok_d;
            if (inc_len && err_len_q != '1) begin
                err_len_q <= err_len_q + 1'b1;
            end
            if (inc_csum && err_csum_q != '1) begin
                err_csum_q <= err_csum_q + 1'b1;
            end
            if (inc_timeout && err_timeout_q != '1) begin
                err_timeout_q <= err_timeout_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[widx_q[AW-1:0]] <= s_axis_tdata;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = (state_q == StDrain);
    assign m_axis_tdata  = mem_q[ridx_q[AW-1:0]];
    assign m_axis_tlast  = (state_q == StDrain) && m_last;
    assign frame_ok      = frame_ok_q;
    assign err_len       = err_len_q;
    assign err_csum      = err_csum_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_host_frame_rx.sv
// Directed bench for host_frame_rx: good/bad frames, length errors, timeout,
// output backpressure and reset mid-payload.
`timescale 1ns / 1ps
module tb_host_frame_rx;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             m_axis_tlast;
    logic             frame_ok;
    logic [CNT_W-1:0] err_len;
    logic [CNT_W-1:0] err_csum;
    logic [CNT_W-1:0] err_timeout;

    host_frame_rx #(
        .MAX_LEN        (64),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_ok      (frame_ok),
        .err_len       (err_len),
        .err_csum      (err_csum),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] got_data [$];
    logic       got_last [$];
    int         ok_pulses    = 0;
    int         rdy_in_drain = 0;
    int         unstable     = 0;
    int         ok0;
    logic       rand_ready = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    logic [7:0] t1 [$];
    logic [7:0] bad [$];
    logic [7:0] big [$];

    always @(negedge clk) begin
        m_axis_tready <= rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_data.push_back(m_axis_tdata);
            got_last.push_back(m_axis_tlast);
        end
        if (frame_ok) ok_pulses <= ok_pulses + 1;
        if (m_axis_tvalid && s_axis_tready) rdy_in_drain <= rdy_in_drain + 1;
        if (prev_stall && m_axis_tvalid &&
            (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last)) begin
            unstable <= unstable + 1;
        end
        prev_stall <= m_axis_tvalid && !m_axis_tready;
        prev_data  <= m_axis_tdata;
        prev_last  <= m_axis_tlast;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(s_axis_tready), 32'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes [$]);
        foreach (bytes[i]) send(bytes[i]);
        idle();
    endtask

    task automatic wait_out(input string tag, input int n);
        int c = 0;
        while (got_data.size() < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(got_data.size()), 32'(n));
    endtask

    task automatic check_t1(input string tag);
        wait_out(tag, 3);
        if (got_data.size() >= 3) begin
            check({tag, "_b0"}, 32'(got_data[0]), 32'h11);
            check({tag, "_b1"}, 32'(got_data[1]), 32'h22);
            check({tag, "_b2"}, 32'(got_data[2]), 32'h33);
            check({tag, "_last"}, {29'd0, got_last[0], got_last[1], got_last[2]}, 32'b001);
        end
        got_data.delete();
        got_last.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        t1  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        bad = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        // 0x40 + sum(0..63)=0x7E0 -> 0x20 mod 256, so CSUM = 0xE0
        big = '{8'hA5, 8'h40};
        for (int i = 0; i < 64; i++) big.push_back(8'(i));
        big.push_back(8'hE0);

        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_counters", {err_len, err_csum} | 32'(err_timeout), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_tready", 32'(s_axis_tready), 32'd1);

        // T1 good frame
        ok0 = ok_pulses;
        send_frame(t1);
        check_t1("t1");
        check("t1_frame_ok", 32'(ok_pulses - ok0), 32'd1);
        check("t1_counters", {err_len, err_csum} | 32'(err_timeout), 32'd0);

        // T2 bad checksum then good frame
        ok0 = ok_pulses;
        send_frame(bad);
        repeat (3) @(posedge clk);
        #1;
        check("t2_err_csum", 32'(err_csum), 32'd1);
        check("t2_no_output", 32'(got_data.size()), 32'd0);
        check("t2_no_ok", 32'(ok_pulses - ok0), 32'd0);
        send_frame(t1);
        check_t1("t2");

        // T3 length errors
        send_frame('{8'hA5, 8'h00});
        send_frame('{8'hA5, 8'h41});
        repeat (2) @(posedge clk);
        #1;
        check("t3_err_len", 32'(err_len), 32'd2);
        check("t3_no_output", 32'(got_data.size()), 32'd0);
        send_frame(t1);
        check_t1("t3");
        check("t3_err_len_after", 32'(err_len), 32'd2);

        // T4 timeout after 16 idle cycles mid-payload
        send(8'hA5);
        send(8'h02);
        send(8'hAA);
        idle();
        repeat (15) @(posedge clk);
        #1;
        check("t4_no_timeout_15", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        check("t4_timeout_16", 32'(err_timeout), 32'd1);
        send_frame(t1);
        check_t1("t4");

        // T5 full-size frame with random output backpressure
        rdy_in_drain = 0;
        unstable     = 0;
        rand_ready   = 1'b1;
        send_frame(big);
        wait_out("t5", 64);
        rand_ready = 1'b0;
        if (got_data.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                check("t5_byte", 32'(got_data[i]), 32'(i));
                check("t5_last", 32'(got_last[i]), 32'(i == 63));
            end
        end
        got_data.delete();
        got_last.delete();
        check("t5_tready_in_drain", 32'(rdy_in_drain), 32'd0);
        check("t5_stable_under_stall", 32'(unstable), 32'd0);
        check("t5_err_timeout", 32'(err_timeout), 32'd1);

        // T6 reset mid-payload
        send(8'hA5);
        send(8'h08);
        for (int i = 1; i <= 5; i++) send(8'(i));
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst           = 1'b1;
        #1;
        check("t6_tready", 32'(s_axis_tready), 32'd0);
        check("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t6_tlast", 32'(m_axis_tlast), 32'd0);
        check("t6_counters", {err_len, err_csum} | 32'(err_timeout), 32'd0);
        @(negedge clk) rst = 1'b0;
        ok0 = ok_pulses;
        send_frame(t1);
        check_t1("t6");
        check("t6_frame_ok", 32'(ok_pulses - ok0), 32'd1);
        check("t6_counters_after", {err_len, err_csum} | 32'(err_timeout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
